// File: rtl/ethernet_rx_frame_parser.sv
// Receive-side Ethernet parser: captures the 42-byte ARP/IPv4 header, filters against the
// local MAC/IP, and serializes ICMP/UDP payload bytes one per cycle.
module ethernet_rx_frame_parser #(
    parameter logic [47:0] FPGA_MAC         = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP          = 32'hC0000186,
    parameter int unsigned ICMP_MAX_PAYLOAD = 63
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [63:0]  i_data,
    input  logic [7:0]   i_keep,
    input  logic         i_valid,
    input  logic         i_last,
    output logic         o_ready,
    output logic [335:0] o_hdr,
    output logic         o_is_arp,
    output logic         o_is_icmp,
    output logic         o_is_udp,
    output logic         o_hdr_valid,
    output logic [7:0]   o_payload_word,
    output logic         o_icmp_valid,
    output logic         o_udp_valid,
    output logic         o_frame_done,
    output logic         o_drop
);

    localparam logic [1:0] S_HDR     = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_ARP     = 2'd3;
    localparam logic [15:0] ICMP_MAX = 16'(ICMP_MAX_PAYLOAD);

    logic [1:0]   state_q, state_d;
    logic [2:0]   w_q, w_d;
    logic [319:0] shadow_q, shadow_d;
    logic [335:0] hdr_q, hdr_d;
    logic         is_arp_q, is_arp_d, is_icmp_q, is_icmp_d, is_udp_q, is_udp_d;
    logic         hdr_valid_q, hdr_valid_d, done_q, done_d, drop_q, drop_d;
    logic [7:0]   pay_q, pay_d;
    logic         icmp_v_q, icmp_v_d, udp_v_q, udp_v_d;
    logic [63:0]  buf_q, buf_d;
    logic [3:0]   rem_q, rem_d;
    logic [15:0]  len_q, len_d;
    logic         last_q, last_d;

    logic         accept;
    logic [3:0]   nkeep;
    logic [335:0] hdr_full;
    logic [47:0]  mac_dst;
    logic [15:0]  ethertype, oper, tot_len, pay_len;
    logic [31:0]  tpa, ip_dst;
    logic [7:0]   ver_ihl, proto, icmp_type;
    logic         mac_uni, mac_bcast, arp_ok, ip_ok, icmp_ok, udp_ok;
    logic         emit, emit_icmp, emit_udp;
    logic [7:0]   emit_byte;
    logic [15:0]  emit_len;
    logic [3:0]   ld_n;

    assign o_ready = (state_q != S_PAYLOAD) || ((rem_q <= 4'd1) && !last_q);
    assign accept  = i_valid && o_ready;

    always_comb begin
        nkeep = '0;
        for (int unsigned b = 0; b < 8; b++) nkeep = nkeep + {3'b000, i_keep[b]};
    end

    // Word 5 contributes header bytes 40..41 from its top two lanes.
    assign hdr_full  = {shadow_q, i_data[63:48]};
    assign mac_dst   = hdr_full[335:288];
    assign ethertype = hdr_full[239:224];
    assign ver_ihl   = hdr_full[223:216];
    assign tot_len   = hdr_full[207:192];
    assign oper      = hdr_full[175:160];
    assign proto     = hdr_full[151:144];
    assign ip_dst    = hdr_full[95:64];
    assign icmp_type = hdr_full[63:56];
    assign tpa       = hdr_full[31:0];
    assign pay_len   = tot_len - 16'd28;

    assign mac_uni   = (mac_dst == FPGA_MAC);
    assign mac_bcast = (mac_dst == '1);
    assign arp_ok    = (ethertype == 16'h0806) && (oper == 16'd1) && (tpa == FPGA_IP)
                       && (mac_uni || mac_bcast);
    assign ip_ok     = (ethertype == 16'h0800) && (ver_ihl == 8'h45) && (ip_dst == FPGA_IP)
                       && mac_uni && (tot_len >= 16'd28);
    assign icmp_ok   = ip_ok && (proto == 8'd1) && (icmp_type == 8'd8) && (pay_len <= ICMP_MAX);
    assign udp_ok    = ip_ok && (proto == 8'd17);
    assign ld_n      = nkeep - 4'd2;

    always_comb begin
        state_d = state_q;  w_d = w_q;  shadow_d = shadow_q;  hdr_d = hdr_q;
        is_arp_d = is_arp_q;  is_icmp_d = is_icmp_q;  is_udp_d = is_udp_q;
        hdr_valid_d = 1'b0;  done_d = 1'b0;  drop_d = 1'b0;
        pay_d = pay_q;  icmp_v_d = 1'b0;  udp_v_d = 1'b0;
        buf_d = buf_q;  rem_d = rem_q;  len_d = len_q;  last_d = last_q;
        emit = 1'b0;  emit_byte = '0;  emit_len = len_q;
        emit_icmp = is_icmp_q;  emit_udp = is_udp_q;

        case (state_q)
            S_HDR: if (accept) begin
                if (w_q != 3'd5) begin
                    shadow_d = {shadow_q[255:0], i_data};
                    if (i_last) begin
                        drop_d = 1'b1;
                        w_d    = '0;
                    end else begin
                        w_d = w_q + 3'd1;
                    end
                end else begin
                    w_d = '0;
                    if (nkeep < 4'd2) begin
                        drop_d  = 1'b1;
                        state_d = i_last ? S_HDR : S_DISCARD;
                    end else begin
                        hdr_d     = hdr_full;
                        is_arp_d  = arp_ok;
                        is_icmp_d = icmp_ok;
                        is_udp_d  = udp_ok;
                        if (arp_ok) begin
                            hdr_valid_d = 1'b1;
                            if (i_last) done_d = 1'b1;
                            else        state_d = S_ARP;
                        end else if (icmp_ok || udp_ok) begin
                            hdr_valid_d = 1'b1;
                            state_d     = S_PAYLOAD;
                            len_d       = pay_len;
                            last_d      = i_last;
                            emit_len    = pay_len;
                            emit_icmp   = icmp_ok;
                            emit_udp    = udp_ok;
                            // Byte 42 goes straight out; bytes 43..47 wait in the buffer.
                            if (ld_n != 4'd0) begin
                                emit      = 1'b1;
                                emit_byte = i_data[47:40];
                                buf_d     = {i_data[39:0], 24'h0};
                                rem_d     = ld_n - 4'd1;
                            end else begin
                                rem_d = '0;
                            end
                        end else begin
                            drop_d  = 1'b1;
                            state_d = i_last ? S_HDR : S_DISCARD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if ((rem_q == 4'd0) && last_q) begin
                    if (len_q == 16'd0) done_d = 1'b1;
                    else                drop_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_HDR;
                end else if (rem_q != 4'd0) begin
                    emit      = 1'b1;
                    emit_byte = buf_q[63:56];
                    buf_d     = {buf_q[55:0], 8'h0};
                    rem_d     = rem_q - 4'd1;
                    if (accept) begin
                        buf_d  = i_data;
                        rem_d  = nkeep;
                        last_d = i_last;
                    end
                end else if (accept) begin
                    emit      = 1'b1;
                    emit_byte = i_data[63:56];
                    buf_d     = {i_data[55:0], 8'h0};
                    rem_d     = nkeep - 4'd1;
                    last_d    = i_last;
                end
            end
            S_ARP: if (accept && i_last) begin
                done_d  = 1'b1;
                state_d = S_HDR;
            end
            default: if (accept && i_last) state_d = S_HDR;
        endcase

        // Bytes past the IP length are padding: consumed but never flagged valid.
        if (emit) begin
            pay_d = emit_byte;
            if (emit_len != 16'd0) begin
                icmp_v_d = emit_icmp;
                udp_v_d  = emit_udp;
                len_d    = emit_len - 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_HDR;  w_q <= '0;  shadow_q <= '0;  hdr_q <= '0;
            is_arp_q <= 1'b0;  is_icmp_q <= 1'b0;  is_udp_q <= 1'b0;
            hdr_valid_q <= 1'b0;  done_q <= 1'b0;  drop_q <= 1'b0;
            pay_q <= '0;  icmp_v_q <= 1'b0;  udp_v_q <= 1'b0;
            buf_q <= '0;  rem_q <= '0;  len_q <= '0;  last_q <= 1'b0;
        end else begin
            state_q <= state_d;  w_q <= w_d;  shadow_q <= shadow_d;  hdr_q <= hdr_d;
            is_arp_q <= is_arp_d;  is_icmp_q <= is_icmp_d;  is_udp_q <= is_udp_d;
            hdr_valid_q <= hdr_valid_d;  done_q <= done_d;  drop_q <= drop_d;
            pay_q <= pay_d;  icmp_v_q <= icmp_v_d;  udp_v_q <= udp_v_d;
            buf_q <= buf_d;  rem_q <= rem_d;  len_q <= len_d;  last_q <= last_d;
        end
    end

    assign o_hdr          = hdr_q;
    assign o_is_arp       = is_arp_q;
    assign o_is_icmp      = is_icmp_q;
    assign o_is_udp       = is_udp_q;
    assign o_hdr_valid    = hdr_valid_q;
    assign o_payload_word = pay_q;
    assign o_icmp_valid   = icmp_v_q;
    assign o_udp_valid    = udp_v_q;
    assign o_frame_done   = done_q;
    assign o_drop         = drop_q;

endmodule

// File: tb/tb_ethernet_rx_frame_parser.sv
// Scoreboard bench for ethernet_rx_frame_parser: frames are built byte-wise, expected
// class/payload/end events are queued at build time and popped as the DUT produces them.
module tb_ethernet_rx_frame_parser;

    localparam logic [47:0] MAC = 48'h211abcdef112;
    localparam logic [31:0] IP  = 32'hC0000186;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  i_data;
    logic [7:0]   i_keep;
    logic         i_valid, i_last;
    logic         o_ready, o_is_arp, o_is_icmp, o_is_udp, o_hdr_valid;
    logic [335:0] o_hdr;
    logic [7:0]   o_payload_word;
    logic         o_icmp_valid, o_udp_valid, o_frame_done, o_drop;

    ethernet_rx_frame_parser #(
        .FPGA_MAC(MAC), .FPGA_IP(IP), .ICMP_MAX_PAYLOAD(63)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_data(i_data), .i_keep(i_keep),
        .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready), .o_hdr(o_hdr),
        .o_is_arp(o_is_arp), .o_is_icmp(o_is_icmp), .o_is_udp(o_is_udp),
        .o_hdr_valid(o_hdr_valid), .o_payload_word(o_payload_word),
        .o_icmp_valid(o_icmp_valid), .o_udp_valid(o_udp_valid),
        .o_frame_done(o_frame_done), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc = -1;
    int last_cyc = -2;
    int pay_seen = 0;
    bit abort_tx = 1'b0;

    logic [9:0]   exp_pay[$];   // {udp, icmp, byte}
    logic [1:0]   exp_evt[$];   // {drop, done}
    logic [2:0]   exp_cls[$];   // {arp, icmp, udp}
    logic [7:0]   fr[0:255];
    int           fr_len;
    logic [335:0] exp_hdr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst) begin
        if (o_icmp_valid || o_udp_valid) begin
            pay_seen++;
            if (exp_pay.size() == 0)
                check_eq("unexpected_byte", {o_udp_valid, o_icmp_valid, o_payload_word}, 64'h0);
            else
                check_eq("payload", {o_udp_valid, o_icmp_valid, o_payload_word}, exp_pay.pop_front());
        end
        if (o_hdr_valid) begin
            if (exp_cls.size() == 0) check_eq("unexpected_hdr_valid", 1, 0);
            else check_eq("class", {o_is_arp, o_is_icmp, o_is_udp}, exp_cls.pop_front());
            if (o_is_icmp || o_is_udp)
                check_eq("first_byte_with_hdr_valid", o_icmp_valid | o_udp_valid, 1);
        end
        if (o_frame_done || o_drop) begin
            if (o_frame_done) done_cyc = cyc;
            if (exp_evt.size() == 0) check_eq("unexpected_event", {o_drop, o_frame_done}, 0);
            else check_eq("end_event", {o_drop, o_frame_done}, exp_evt.pop_front());
        end
    end

    task automatic build_eth(input logic [47:0] dst, input logic [15:0] et, input int len);
        fr_len = len;
        for (int i = 0; i < 256; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fr[i]     = dst[47-8*i -: 8];
            fr[6 + i] = 8'h02 + 8'(i);
        end
        fr[12] = et[15:8];
        fr[13] = et[7:0];
    endtask

    task automatic build_arp(input logic [47:0] dst, input logic [15:0] oper, input logic [31:0] tpa);
        build_eth(dst, 16'h0806, 60);
        fr[15] = 8'h01; fr[16] = 8'h08; fr[18] = 8'h06; fr[19] = 8'h04;
        fr[20] = oper[15:8]; fr[21] = oper[7:0];
        fr[28] = 8'hC0; fr[30] = 8'h01; fr[31] = 8'h01;
        for (int i = 0; i < 4; i++) fr[38 + i] = tpa[31-8*i -: 8];
    endtask

    task automatic build_ip(input logic [47:0] dmac, input logic [31:0] dip, input logic [7:0] proto,
                            input logic [7:0] typ, input logic [15:0] tot_len, input int len);
        build_eth(dmac, 16'h0800, len);
        fr[14] = 8'h45; fr[16] = tot_len[15:8]; fr[17] = tot_len[7:0];
        fr[22] = 8'h40; fr[23] = proto;
        fr[26] = 8'hC0; fr[28] = 8'h01; fr[29] = 8'h01;
        for (int i = 0; i < 4; i++) fr[30 + i] = dip[31-8*i -: 8];
        fr[34] = typ;
        for (int i = 35; i < len; i++) fr[i] = (i < 14 + int'(tot_len)) ? 8'($urandom) : 8'h00;
    endtask

    task automatic expect_ip_pass(input logic udp, input logic [15:0] tot_len);
        int stop;
        stop = 14 + int'(tot_len);
        if (stop > fr_len) stop = fr_len;
        exp_cls.push_back({1'b0, ~udp, udp});
        for (int i = 42; i < stop; i++) exp_pay.push_back({udp, ~udp, fr[i]});
        exp_evt.push_back((fr_len >= 14 + int'(tot_len)) ? 2'b01 : 2'b10);
    endtask

    task automatic note_hdr();
        if (fr_len >= 42)
            for (int i = 0; i < 42; i++) exp_hdr[335-8*i -: 8] = fr[i];
    endtask

    task automatic send_frame(input int gap);
        int nw;
        nw = (fr_len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            bit acc;
            if (abort_tx) break;
            i_data = '0;
            i_keep = '0;
            for (int b = 0; b < 8; b++)
                if (8*w + b < fr_len) begin
                    i_data[63-8*b -: 8] = fr[8*w + b];
                    i_keep[7-b] = 1'b1;
                end
            i_last  = (w == nw - 1);
            i_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                if (abort_tx) break;
                if (o_ready) begin
                    @(posedge clk);
                    #1;
                    acc = 1'b1;
                end
            end
            if (!acc && !abort_tx) begin
                check_eq("accept_timeout", 0, 1);
                break;
            end
            if (acc && i_last) last_cyc = cyc;
            i_valid = 1'b0;
            if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 400; t++) begin
            if (exp_pay.size() == 0 && exp_evt.size() == 0 && exp_cls.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_left_bytes"}, exp_pay.size(), 0);
        check_eq({tag, "_left_events"}, exp_evt.size() + exp_cls.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_keep = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ready", o_ready, 1);
        check_eq("reset_flags", {o_is_arp, o_is_icmp, o_is_udp, o_hdr_valid, o_icmp_valid,
                                 o_udp_valid, o_frame_done, o_drop}, 0);
        check_eq("reset_hdr", o_hdr[335:272] | o_hdr[63:0], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ARP request, broadcast, 60 bytes
        build_arp('1, 16'd1, IP); note_hdr();
        exp_cls.push_back(3'b100); exp_evt.push_back(2'b01);
        send_frame(0); wait_drain("arp_bcast");
        check_eq("arp_done_latency", done_cyc - last_cyc, 0);
        check_eq("arp_mac_dst", o_hdr[335:288], 48'hffffffffffff);
        check_eq("arp_hdr_tail", o_hdr[63:0], exp_hdr[63:0]);

        // ARP for another IP, then a good unicast ARP
        build_arp(MAC, 16'd1, 32'hC0000187); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("arp_wrong_tpa");
        check_eq("arp_wrong_tpa_class", {o_is_arp, o_is_icmp, o_is_udp}, 0);
        build_arp(MAC, 16'd1, IP); note_hdr();
        exp_cls.push_back(3'b100); exp_evt.push_back(2'b01);
        send_frame(1); wait_drain("arp_unicast");

        // ICMP echo, 32-byte payload
        build_ip(MAC, IP, 8'd1, 8'd8, 16'd60, 74); note_hdr();
        expect_ip_pass(1'b0, 16'd60);
        send_frame(0); wait_drain("icmp32");
        check_eq("icmp32_hdr_top", o_hdr[335:272], exp_hdr[335:272]);

        // UDP 10-byte payload padded to 60
        build_ip(MAC, IP, 8'd17, 8'h00, 16'd38, 60); note_hdr();
        expect_ip_pass(1'b1, 16'd38);
        send_frame(0); wait_drain("udp_pad");

        // UDP truncated by i_last: buffered bytes out, then drop
        build_ip(MAC, IP, 8'd17, 8'h00, 16'd60, 60); note_hdr();
        expect_ip_pass(1'b1, 16'd60);
        send_frame(0); wait_drain("udp_trunc");

        // ICMP payload at the 63-byte limit passes, with input stalls
        build_ip(MAC, IP, 8'd1, 8'd8, 16'd91, 105); note_hdr();
        expect_ip_pass(1'b0, 16'd91);
        send_frame(3); wait_drain("icmp63");

        // Drops: 64-byte ICMP, 92-byte ICMP, IPv4 to broadcast MAC, tot_len < 28
        build_ip(MAC, IP, 8'd1, 8'd8, 16'd92, 106); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("icmp64");
        build_ip(MAC, IP, 8'd1, 8'd8, 16'd120, 134); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("icmp92");
        build_ip('1, IP, 8'd17, 8'h00, 16'd38, 60); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("ip_bcast");
        build_ip(MAC, IP, 8'd17, 8'h00, 16'd20, 60); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("udp_short_len");

        // Short 3-word frame: drop, header register untouched
        build_ip(MAC, IP, 8'd17, 8'h00, 16'd60, 24); note_hdr();
        exp_evt.push_back(2'b10);
        send_frame(0); wait_drain("short");
        check_eq("short_hdr_top", o_hdr[335:272], exp_hdr[335:272]);
        check_eq("short_hdr_tail", o_hdr[63:0], exp_hdr[63:0]);

        // Reset during the fourth UDP payload byte
        build_ip(MAC, IP, 8'd17, 8'h00, 16'd60, 74);
        expect_ip_pass(1'b1, 16'd60);
        pay_seen = 0;
        fork
            send_frame(0);
            begin
                for (int t = 0; t < 300; t++) begin
                    @(negedge clk);
                    #1;
                    if (pay_seen >= 4) break;
                end
                check_eq("reset_at_byte", pay_seen, 4);
                rst = 1'b1;
                abort_tx = 1'b1;
                #1;
                check_eq("midreset_udp_valid", o_udp_valid, 0);
                check_eq("midreset_ready", o_ready, 1);
            end
        join
        i_valid = 1'b0; i_last = 1'b0;
        exp_pay.delete(); exp_evt.delete(); exp_cls.delete();
        @(posedge clk); #1;
        rst = 1'b0; abort_tx = 1'b0;
        @(posedge clk); #1;

        build_ip(MAC, IP, 8'd1, 8'd8, 16'd40, 60); note_hdr();
        expect_ip_pass(1'b0, 16'd40);
        send_frame(2); wait_drain("icmp_after_reset");
        check_eq("after_reset_hdr_top", o_hdr[335:272], exp_hdr[335:272]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
